clint: RTL and testbench

- Core-local interruptor, directly upstream of the exception unit.
- Holds a 64-bit machine timer mtime, a 64-bit compare register mtimecmp and a software-interrupt bit msip.
- Produces a registered level timer_irq_o, which the exception unit gates with mstatus.MIE.
- Slave on the core's simple 32-bit data-bus port; every access takes one cycle.

---
 rtl/clint_pkg.sv | 33 +++
 rtl/clint_prescaler.sv | 34 +++
 rtl/clint.sv | 111 +++++++++++
 tb/tb_clint.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared CLINT definitions: register offsets, reset values and the decoded bus request.
package clint_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MTIME_W = 64;
  localparam int unsigned OFF_W   = 16;

  localparam logic [OFF_W-1:0] CLINT_MSIP        = 16'h0000;
  localparam logic [OFF_W-1:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [OFF_W-1:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [OFF_W-1:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [OFF_W-1:0] CLINT_MTIME_HI    = 16'hBFFC;

  // All-ones keeps the timer interrupt quiet until software programs a deadline.
  localparam logic [MTIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } clint_reg_e;

  typedef struct packed {
    logic             req;
    logic             we;
    clint_reg_e       sel;
    logic [XLEN-1:0]  wdata;
  } clint_bus_req_t;

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk into one-cycle tick pulses every TICK_DIV cycles; TICK_DIV=1 ticks every cycle.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // tick_q mirrors (cnt_q == LAST) so the tick is available straight from a flop.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= (TICK_DIV == 1);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp/msip registers behind a single-cycle 32-bit slave port.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  timer_irq_o,
  output logic                  soft_irq_o
);

  logic tick;

  clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  logic [MTIME_W-1:0]    mtime_q, mtime_d;
  logic [MTIME_W-1:0]    mtimecmp_q, mtimecmp_d;
  logic                  msip_q, msip_d;
  logic                  rvalid_q, rvalid_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic                  irq_q, irq_d;
  logic [ADDR_WIDTH-1:0] off;
  clint_bus_req_t        bus;
  logic [1:0]            unused_addr_lsb;

  assign unused_addr_lsb = addr_i[1:0];

  // Decode the word-aligned offset; anything unmapped becomes REG_NONE.
  always_comb begin
    off       = {addr_i[ADDR_WIDTH-1:2], 2'b00};
    bus.req   = req_i;
    bus.we    = we_i;
    bus.wdata = wdata_i;
    if      (off == ADDR_WIDTH'(CLINT_MSIP))        bus.sel = REG_MSIP;
    else if (off == ADDR_WIDTH'(CLINT_MTIMECMP_LO)) bus.sel = REG_CMP_LO;
    else if (off == ADDR_WIDTH'(CLINT_MTIMECMP_HI)) bus.sel = REG_CMP_HI;
    else if (off == ADDR_WIDTH'(CLINT_MTIME_LO))    bus.sel = REG_TIME_LO;
    else if (off == ADDR_WIDTH'(CLINT_MTIME_HI))    bus.sel = REG_TIME_HI;
    else                                            bus.sel = REG_NONE;
  end

  // A bus write to either mtime half overrides that cycle's increment without carrying.
  always_comb begin
    mtime_d    = tick ? mtime_q + MTIME_W'(1) : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (bus.req && bus.we) begin
      case (bus.sel)
        REG_MSIP:    msip_d                = bus.wdata[0];
        REG_CMP_LO:  mtimecmp_d[31:0]      = bus.wdata;
        REG_CMP_HI:  mtimecmp_d[63:32]     = bus.wdata;
        REG_TIME_LO: mtime_d               = {mtime_q[63:32], bus.wdata};
        REG_TIME_HI: mtime_d               = {bus.wdata, mtime_q[31:0]};
        default:     ;
      endcase
    end
  end

  // Responses and the interrupt level are computed from pre-update register values.
  always_comb begin
    rvalid_d = bus.req;
    rdata_d  = '0;
    irq_d    = (mtime_q >= mtimecmp_q);
    if (bus.req && !bus.we) begin
      case (bus.sel)
        REG_MSIP:    rdata_d = {{(XLEN-1){1'b0}}, msip_q};
        REG_CMP_LO:  rdata_d = mtimecmp_q[31:0];
        REG_CMP_HI:  rdata_d = mtimecmp_q[63:32];
        REG_TIME_LO: rdata_d = mtime_q[31:0];
        REG_TIME_HI: rdata_d = mtime_q[63:32];
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      msip_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign timer_irq_o = irq_q;
  assign soft_irq_o  = msip_q;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: two instances (TICK_DIV=1 and 4) on a shared bus against a behavioural model.
module tb_clint;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req, we;
  logic [15:0] addr;
  logic [31:0] wdata;

  logic        a_rvalid, b_rvalid, a_tirq, b_tirq, a_sirq, b_sirq;
  logic [31:0] a_rdata, b_rdata;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  clint #(.ADDR_WIDTH(16), .TICK_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(a_rvalid), .rdata_o(a_rdata), .timer_irq_o(a_tirq), .soft_irq_o(a_sirq)
  );

  clint #(.ADDR_WIDTH(16), .TICK_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(b_rvalid), .rdata_o(b_rdata), .timer_irq_o(b_tirq), .soft_irq_o(b_sirq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  logic        m_msip [2];
  int unsigned m_presc[2];
  logic [31:0] m_rdata[2];
  logic        m_tirq [2];
  logic        m_rvalid;

  function automatic int unsigned td(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] m_read(input int k, input logic [15:0] a);
    case (a & 16'hFFFC)
      16'h0000: return {31'b0, m_msip[k]};
      16'h4000: return m_cmp[k][31:0];
      16'h4004: return m_cmp[k][63:32];
      16'hBFF8: return m_time[k][31:0];
      16'hBFFC: return m_time[k][63:32];
      default:  return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_time[k] = 64'h0; m_cmp[k] = '1; m_msip[k] = 1'b0; m_presc[k] = 0;
        m_rdata[k] = 32'h0; m_tirq[k] = 1'b0;
      end
      m_rvalid = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin : per_inst
        logic tick, wr_time;
        m_rdata[k] = (req && !we) ? m_read(k, addr) : 32'h0;
        m_tirq[k]  = (m_time[k] >= m_cmp[k]);
        tick       = (m_presc[k] == td(k) - 1);
        m_presc[k] = tick ? 0 : m_presc[k] + 1;
        wr_time    = 1'b0;
        if (req && we) begin
          case (addr & 16'hFFFC)
            16'h0000: m_msip[k] = wdata[0];
            16'h4000: m_cmp[k][31:0]  = wdata;
            16'h4004: m_cmp[k][63:32] = wdata;
            16'hBFF8: begin m_time[k][31:0]  = wdata; wr_time = 1'b1; end
            16'hBFFC: begin m_time[k][63:32] = wdata; wr_time = 1'b1; end
            default: ;
          endcase
        end
        if (!wr_time && tick) m_time[k] = m_time[k] + 64'd1;
      end
      m_rvalid = req;
    end
  end

  // Every cycle, both instances against the model.
  always @(negedge clk) begin
    chk("a_rvalid", a_rvalid, m_rvalid);
    chk("b_rvalid", b_rvalid, m_rvalid);
    chk("a_rdata",  a_rdata,  m_rdata[0]);
    chk("b_rdata",  b_rdata,  m_rdata[1]);
    chk("a_tirq",   a_tirq,   m_tirq[0]);
    chk("b_tirq",   b_tirq,   m_tirq[1]);
    chk("a_sirq",   a_sirq,   m_msip[0]);
    chk("b_sirq",   b_sirq,   m_msip[1]);
  end

  // ---------------- directed stimulus ----------------
  // Called at a negedge; returns at the next negedge with the response sampled.
  task automatic bus(input logic w, input logic [15:0] a, input logic [31:0] d,
                     output logic [31:0] ra, output logic [31:0] rb);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    ra = a_rdata; rb = b_rdata;
    chk("rvalid_pulse", {a_rvalid, b_rvalid}, 2'b11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, r0, r1, r2;
    int c;
    req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {a_rvalid, a_rdata, a_tirq, a_sirq}, 35'h0);
    rst_n = 1'b1;

    // idle after reset
    repeat (10) @(negedge clk);
    bus(1'b0, 16'hBFF8, 32'h0, ra, rb);
    chk("idle_mtime_a_in_range", (ra >= 32'd9 && ra <= 32'd11), 1'b1);
    chk("idle_mtime_b", rb, 32'd2);
    chk("idle_tirq", a_tirq, 1'b0);
    bus(1'b0, 16'h4004, 32'h0, ra, rb);
    chk("cmp_hi_reset", {ra, rb}, 64'hFFFF_FFFF_FFFF_FFFF);

    // timer interrupt rise/fall
    bus(1'b1, 16'h4004, 32'h0, ra, rb);
    bus(1'b1, 16'hBFF8, 32'h0, ra, rb);
    bus(1'b1, 16'h4000, 32'd20, ra, rb);
    c = 1;
    while (!a_tirq && c < 100) begin @(negedge clk); c++; end
    chk("tirq_rise_cycle", 64'(c), 64'd21);
    repeat (5) @(negedge clk);
    chk("tirq_stays", a_tirq, 1'b1);
    bus(1'b1, 16'h4000, 32'd1000, ra, rb);
    chk("tirq_hold_one_cycle", a_tirq, 1'b1);
    @(negedge clk);
    chk("tirq_fall", a_tirq, 1'b0);

    // carry from lo into hi, and lo write without carry
    bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, ra, rb);
    bus(1'b1, 16'hBFFC, 32'h0, ra, rb);
    @(negedge clk);
    bus(1'b0, 16'hBFF8, 32'h0, ra, rb);
    chk("carry_lo", ra, 32'h0);
    bus(1'b0, 16'hBFFC, 32'h0, ra, rb);
    chk("carry_hi", ra, 32'h1);
    bus(1'b1, 16'hBFF8, 32'd5, ra, rb);
    bus(1'b0, 16'hBFFC, 32'h0, ra, rb);
    chk("lo_write_keeps_hi", ra, 32'h1);

    // 64-bit wrap
    bus(1'b1, 16'hBFFC, 32'hFFFF_FFFF, ra, rb);
    bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, ra, rb);
    @(negedge clk);
    bus(1'b0, 16'hBFFC, 32'h0, ra, rb);
    chk("wrap_hi", ra, 32'h0);

    // TICK_DIV=4 rate and dropped increment
    bus(1'b1, 16'hBFFC, 32'h0, ra, rb);
    bus(1'b1, 16'hBFF8, 32'h0, ra, rb);
    repeat (16) @(negedge clk);
    bus(1'b0, 16'hBFF8, 32'h0, ra, rb);
    chk("div4_16cyc", rb, 32'd4);
    c = 0;
    while (m_presc[1] != 3 && c < 8) begin @(negedge clk); c++; end
    bus(1'b1, 16'hBFF8, 32'd100, ra, rb);
    bus(1'b0, 16'hBFF8, 32'h0, ra, rb);
    chk("div4_tick_write", rb, 32'd100);
    repeat (3) @(negedge clk);
    bus(1'b0, 16'hBFF8, 32'h0, ra, rb);
    chk("div4_after_4", rb, 32'd101);

    // software interrupt
    bus(1'b1, 16'h0000, 32'h1, ra, rb);
    chk("sirq_set", {a_sirq, b_sirq}, 2'b11);
    bus(1'b0, 16'h0000, 32'h0, ra, rb);
    chk("msip_read1", {ra, rb}, {32'h1, 32'h1});
    bus(1'b1, 16'h0000, 32'h0, ra, rb);
    chk("sirq_clr", {a_sirq, b_sirq}, 2'b00);
    bus(1'b0, 16'h0000, 32'h0, ra, rb);
    chk("msip_read0", {ra, rb}, 64'h0);

    // back-to-back burst, then reset mid-burst
    req = 1'b1; we = 1'b0; addr = 16'h1234;
    @(negedge clk);
    r0 = a_rdata; chk("b2b_rvalid0", a_rvalid, 1'b1);
    we = 1'b1; addr = 16'h4000; wdata = 32'hCAFE_0001;
    @(negedge clk);
    r1 = a_rdata; chk("b2b_rvalid1", a_rvalid, 1'b1);
    we = 1'b0; addr = 16'h4000;
    @(negedge clk);
    r2 = a_rdata; chk("b2b_rvalid2", a_rvalid, 1'b1);
    chk("b2b_rdata", {r0, r1, r2}, {32'h0, 32'h0, 32'hCAFE_0001});
    chk("b2b_rdata_b", b_rdata, 32'hCAFE_0001);
    addr = 16'hBFF8;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst_outputs", {a_rvalid, a_rdata, a_tirq, a_sirq, b_rvalid, b_rdata, b_tirq, b_sirq}, 70'h0);
    req = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
